restoring_div_ctrl: RTL and testbench
=====================================

RESTORING_DIV_CTRL -- requirements
Module: restoring_div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned dividend; captured on the accepting edge.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned divisor; captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse when results become valid.
REQ-009 SHALL have port dbz, output, 1 bit: divide-by-zero flag for the last completed division.
REQ-010 SHALL have port quotient, output, WIDTH bits: registered quotient; feeds the seven-segment controller.
REQ-011 SHALL have port remainder, output, WIDTH bits: registered remainder; feeds the seven-segment controller.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE, plus an iteration counter of $clog2(WIDTH+1) bits.
REQ-013 IDLE with start=1 at edge E0: SHALL capture the operands, clear the accumulator A (WIDTH+1 bits), load Q=dividend, M=divisor, set the counter to WIDTH and enter RUN; busy SHALL be 1 after E0.
REQ-014 RUN: each edge SHALL shift {A,Q} left by 1, compute A-M, keep the difference and set Q[0]=1 if it is non-negative, otherwise restore A and set Q[0]=0, then decrement the counter.
REQ-015 RUN SHALL last exactly WIDTH edges (E1..EWIDTH) and then enter DONE.
REQ-016 DONE edge (E(WIDTH+1)): SHALL register quotient=Q and remainder=A[WIDTH-1:0], pulse done=1 for exactly one cycle, drop busy to 0 and return to IDLE.
REQ-017 Latency SHALL be WIDTH+1 edges from start acceptance to the done assertion (17 for WIDTH=16).
REQ-018 start SHALL be ignored in RUN and DONE; no queuing; operand changes after E0 SHALL have no effect.
REQ-019 quotient, remainder and dbz SHALL hold their values until the next done pulse.
REQ-020 All arithmetic SHALL be unsigned; the subtraction SHALL use WIDTH+1 bits, with the sign bit deciding restore.
REQ-021 start held high continuously SHALL start a new division on the first IDLE edge after each DONE.

Reset
REQ-022 rst=1 at any edge SHALL force IDLE with busy=0, done=0, dbz=0, quotient=0, remainder=0, and clear A, Q, M and the counter.
REQ-023 rst mid-RUN SHALL abort the operation with no done pulse; rst SHALL take priority over a simultaneous start.

Configuration
REQ-024 With macro DIV_ZERO_DETECT_EN defined: divisor==0 at E0 SHALL skip RUN and enter DONE directly; at E1 it SHALL produce quotient={WIDTH{1}}, remainder=dividend, dbz=1 and done=1.
REQ-025 Without DIV_ZERO_DETECT_EN: divisor==0 SHALL run the normal WIDTH iterations, yielding quotient={WIDTH{1}} and remainder=dividend at E(WIDTH+1); dbz SHALL be tied to 0.
REQ-026 With DIV_ZERO_DETECT_EN defined, a nonzero divisor SHALL clear dbz at its done edge.

Verification
REQ-027 dividend=0x1234, divisor=0x00AB, start at E0 -> done at E17 with quotient=0x001B and remainder=0x002B; busy high E1..E16.
REQ-028 Back-to-back operations, 100/7 then 5/10 with start held high -> first done gives 0x000E r 0x0002; second done (18 edges later) gives 0x0000 r 0x0005.
REQ-029 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0x0000; start pulses during RUN are ignored and the result is unchanged.
REQ-030 0x00AB/0x0000 -> with DIV_ZERO_DETECT_EN: done at E1 with dbz=1, Q=0xFFFF, R=0x00AB; without it: done at E17 with dbz=0 and the same Q and R.
REQ-031 rst asserted at E8 of a 0x1234/0x00AB run -> no done pulse, all outputs 0; a new start then completes normally 17 edges later.

Source files
------------

// File: rtl/restoring_div_ctrl.sv
// Multi-cycle unsigned restoring divider: IDLE -> RUN (WIDTH iterations) -> DONE.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor skips RUN and raises dbz.
module restoring_div_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   a_diff;
  logic             zero_div;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
  assign dbz      = 1'b0;
`endif

  assign busy = (state != IDLE);

  // A always stays below M, so the shifted value fits in WIDTH+1 bits and the
  // MSB of the difference is the restore decision.
  always_comb begin
    a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
    a_diff  = a_shift - {1'b0, m};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = zero_div ? DONE : RUN;
      RUN:  if (cnt == CW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a   <= '0;
            q   <= dividend;
            m   <= divisor;
            cnt <= CW'(WIDTH);
          end
        end
        RUN: begin
          if (a_diff[WIDTH]) begin
            a <= a_shift;
            q <= {q[WIDTH-2:0], 1'b0};
          end else begin
            a <= a_diff;
            q <= {q[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          done <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          // On the skipped path Q still holds the untouched dividend.
          if (m == '0) begin
            quotient  <= '1;
            remainder <= q;
            dbz       <= 1'b1;
          end else begin
            quotient  <= q;
            remainder <= a[WIDTH-1:0];
            dbz       <= 1'b0;
          end
`else
          quotient  <= q;
          remainder <= a[WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Self-checking bench for restoring_div_ctrl against an arithmetic (/ and %) model.
// Build with or without DIV_ZERO_DETECT_EN to match the RTL configuration.
module tb_restoring_div_ctrl;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;

  restoring_div_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned division, divide-by-zero gives all ones / dividend.
  function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                  output logic [W-1:0] rq, output logic [W-1:0] rr,
                                  output int lat, output logic rdbz);
    if (d == 0) begin
      rq = '1;
      rr = n;
`ifdef DIV_ZERO_DETECT_EN
      lat = 1; rdbz = 1'b1;
`else
      lat = W + 1; rdbz = 1'b0;
`endif
    end else begin
      rq = n / d;
      rr = n % d;
      lat = W + 1; rdbz = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one division and counts edges from acceptance until done (-1 on timeout).
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, output int lat);
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = 16'h1234; divisor = 16'h00AB;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
               busy, done, dbz, quotient, remainder);
    end
    start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    dividend = 16'h1234; divisor = 16'h00AB; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      tick();
      checks++;
      if (k < W + 1) begin
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL directed_busy E%0d: busy=%b done=%b, required busy=1 done=0", k, busy, done);
        end
      end else if (busy !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL directed_done E%0d: busy=%b done=%b, required busy=0 done=1", k, busy, done);
      end
    end
    checks++;
    if (quotient !== 16'h001B || remainder !== 16'h002B || dbz !== 1'b0) begin
      errors++;
      $display("FAIL directed_result: q=%h r=%h dbz=%b, required q=001b r=002b dbz=0",
               quotient, remainder, dbz);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL directed_pulse: done=%b one cycle after pulse, required 0", done);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] n, d, eq, er;
    logic         ed;
    int           el, lat;
    for (int i = 0; i < 30; i++) begin
      n = W'($urandom);
      case ($urandom_range(0, 4))
        0: d = W'($urandom_range(1, 15));
        1: d = 16'd0;
        2: d = 16'hFFFF;
        default: d = W'($urandom);
      endcase
      if (i == 0) begin n = 16'hFFFF; d = 16'hFFFF; end
      if (i == 1) begin n = 16'h0000; d = 16'h0003; end
      ref_div(n, d, eq, er, el, ed);
      do_op(n, d, lat);
      checks++;
      if (lat !== el || quotient !== eq || remainder !== er || dbz !== ed) begin
        errors++;
        $display("FAIL random %h/%h: lat=%0d q=%h r=%h dbz=%b, required lat=%0d q=%h r=%h dbz=%b",
                 n, d, lat, quotient, remainder, dbz, el, eq, er, ed);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    dividend = 16'hFFFF; divisor = 16'h0001; start = 1'b1;
    tick();
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      start    = (k % 3 == 0) && (k < W);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== W + 1 || quotient !== 16'hFFFF || remainder !== 16'h0000) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d q=%h r=%h, required lat=17 q=ffff r=0000",
               lat, quotient, remainder);
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_queue: busy=%b, required 0 (no queued start)", busy);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] hq, hr;
    logic         hd;
    int           lat;
    do_op(16'd1000, 16'd33, lat);
    hq = 16'd30; hr = 16'd10; hd = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dividend = W'($urandom);
      divisor  = W'($urandom);
      tick();
      checks++;
      if (quotient !== hq || remainder !== hr || dbz !== hd || done !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: q=%h r=%h dbz=%b done=%b, required q=%h r=%h dbz=%b done=0",
                 k, quotient, remainder, dbz, done, hq, hr, hd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    tick();
    dividend = 16'd5; divisor = 16'd10;
    t1 = -1; t2 = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done && t1 < 0) begin
        t1 = k;
        checks++;
        if (quotient !== 16'h000E || remainder !== 16'h0002) begin
          errors++;
          $display("FAIL b2b_first: q=%h r=%h, required q=000e r=0002", quotient, remainder);
        end
      end else if (done && t2 < 0) begin
        t2 = k;
        start = 1'b0;
        checks++;
        if (quotient !== 16'h0000 || remainder !== 16'h0005) begin
          errors++;
          $display("FAIL b2b_second: q=%h r=%h, required q=0000 r=0005", quotient, remainder);
        end
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (t1 !== W + 1 || t2 - t1 !== W + 2) begin
      errors++;
      $display("FAIL b2b_timing: first=%0d gap=%0d, required first=17 gap=18", t1, t2 - t1);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen = 1'b0;
    dividend = 16'h1234; divisor = 16'h00AB; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
               busy, done, dbz, quotient, remainder);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone: done pulse seen=%b, required 0", seen);
    end
    do_op(16'h1234, 16'h00AB, lat);
    checks++;
    if (lat !== W + 1 || quotient !== 16'h001B || remainder !== 16'h002B) begin
      errors++;
      $display("FAIL reset_mid_restart: lat=%0d q=%h r=%h, required lat=17 q=001b r=002b",
               lat, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_dbz();
    logic [W-1:0] eq, er;
    logic         ed;
    int           el, lat;
    ref_div(16'h00AB, 16'h0000, eq, er, el, ed);
    do_op(16'h00AB, 16'h0000, lat);
    checks++;
    if (lat !== el || quotient !== 16'hFFFF || remainder !== 16'h00AB || dbz !== ed) begin
      errors++;
      $display("FAIL dbz: lat=%0d q=%h r=%h dbz=%b, required lat=%0d q=ffff r=00ab dbz=%b",
               lat, quotient, remainder, dbz, el, ed);
    end
    tick();
    do_op(16'd9, 16'd4, lat);
    checks++;
    if (dbz !== 1'b0 || quotient !== 16'd2 || remainder !== 16'd1) begin
      errors++;
      $display("FAIL dbz_clear: dbz=%b q=%h r=%h, required dbz=0 q=0002 r=0001",
               dbz, quotient, remainder);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_dbz();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
